pcu_sequencer: RTL

Hardware sequencer that shares the performance-counter unit's control slave among on-chip requesters. It turns per-section go/stop pulses, a global clear request and a snapshot request into correctly ordered single-cycle PCU bus writes and reads. Snapshot results stream out as twelve 32-bit words with valid/ready. It sits between instrumented logic and the PCU, replacing software pokes when cycle-accurate section bracketing is needed.

---
 rtl/pcu_seq_pkg.sv | 47 ++++
 rtl/pcu_req_arb.sv | 72 +++++++
 rtl/pcu_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pcu_seq_pkg.sv
// Shared types and constants for the PCU control-slave sequencer.
// Holds the snapshot read order and the write address/data encodings.
package pcu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_PUSH
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_CLR,
    REQ_STOP,
    REQ_GO,
    REQ_SNAP
  } req_kind_t;

  localparam int          NUM_SEC    = 4;
  localparam int          SNAP_WORDS = 12;
  localparam logic [3:0]  SEC_STRIDE = 4'd4;
  localparam logic [3:0]  GO_OFFSET  = 4'd1;
  localparam logic [31:0] CLR_DATA   = 32'h0000_0001;
  localparam logic [3:0]  LAST_IDX   = 4'd11;

  // Offset 3 of every section is skipped: it is not a counter word.
  localparam logic [3:0] SNAP_ADDR [SNAP_WORDS] = '{
    4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14
  };

  function automatic logic [3:0] snap_addr(input logic [3:0] idx);
    return (idx <= LAST_IDX) ? SNAP_ADDR[idx] : 4'd0;
  endfunction

  function automatic logic [3:0] wr_addr(input req_kind_t kind, input logic [1:0] sec);
    logic [3:0] base;
    base = SEC_STRIDE * {2'b00, sec};
    case (kind)
      REQ_STOP: return base;
      REQ_GO:   return base + GO_OFFSET;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/pcu_req_arb.sv
// Pending-request flags, saturating drop counter and fixed-priority picker.
// A flag taken by the FSM's launch strobe clears, unless re-pulsed on that edge.
module pcu_req_arb
  import pcu_seq_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SEC-1:0] sec_go,
  input  logic [NUM_SEC-1:0] sec_stop,
  input  logic               clr_req,
  input  logic               snap_req,
  input  logic               launch,
  output req_kind_t          req_kind,
  output logic [1:0]         req_sec,
  output logic               pending,
  output logic [DROP_W-1:0]  drop_cnt
);

  logic [NUM_SEC-1:0] go_p, stop_p, go_take, stop_take, go_keep, stop_keep, sec_mask;
  logic               clr_p, snap_p, clr_keep, snap_keep;
  logic [3:0]         n_drop;
  logic [DROP_W:0]    drop_sum;

  always_comb begin
    req_kind = REQ_NONE;
    req_sec  = 2'd0;
    if (clr_p) begin
      req_kind = REQ_CLR;
    end else if (|stop_p) begin
      req_kind = REQ_STOP;
      for (int i = NUM_SEC - 1; i >= 0; i--) if (stop_p[i]) req_sec = 2'(i);
    end else if (|go_p) begin
      req_kind = REQ_GO;
      for (int i = NUM_SEC - 1; i >= 0; i--) if (go_p[i]) req_sec = 2'(i);
    end else if (snap_p) begin
      req_kind = REQ_SNAP;
    end
  end

  assign sec_mask  = 4'b0001 << req_sec;
  assign stop_take = (launch && req_kind == REQ_STOP) ? sec_mask : '0;
  assign go_take   = (launch && req_kind == REQ_GO) ? sec_mask : '0;
  assign stop_keep = stop_p & ~stop_take;
  assign go_keep   = go_p & ~go_take;
  assign clr_keep  = clr_p & ~(launch && req_kind == REQ_CLR);
  assign snap_keep = snap_p & ~(launch && req_kind == REQ_SNAP);

  // Several requests can merge in one cycle; each one counts.
  assign n_drop = 4'($countones(go_keep & sec_go)) + 4'($countones(stop_keep & sec_stop))
                + {3'b000, clr_keep & clr_req} + {3'b000, snap_keep & snap_req};
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(n_drop);
  assign pending  = clr_p | snap_p | (|go_p) | (|stop_p);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_p     <= '0;
      stop_p   <= '0;
      clr_p    <= 1'b0;
      snap_p   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      go_p     <= go_keep | sec_go;
      stop_p   <= stop_keep | sec_stop;
      clr_p    <= clr_keep | clr_req;
      snap_p   <= snap_keep | snap_req;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: rtl/pcu_sequencer.sv
// Serialises section go/stop, clear and snapshot requests onto the PCU slave.
// state     | meaning
// IDLE      | pick highest-priority pending request
// WR        | single-cycle PCU write on the bus
// RD_ADDR   | read address on the bus
// RD_CAP    | capture registered read data into the stream word
// PUSH      | hold stream word until smp_ready
module pcu_sequencer
  import pcu_seq_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        sec_go,
  input  logic [3:0]        sec_stop,
  input  logic              clr_req,
  input  logic              snap_req,
  output logic [3:0]        pcu_address,
  output logic              pcu_write,
  output logic              pcu_begintransfer,
  output logic [31:0]       pcu_writedata,
  input  logic [31:0]       pcu_readdata,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [31:0]       smp_data,
  output logic [3:0]        smp_addr,
  output logic              smp_last,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t     state_q, state_d;
  req_kind_t  req_kind;
  logic [1:0] req_sec;
  logic       pending, launch;
  logic [3:0] idx_q, idx_d, address_d, smp_addr_d;
  logic [31:0] writedata_d, smp_data_d;
  logic       write_d, bt_d, smp_valid_d, smp_last_d;

  pcu_req_arb #(.DROP_W(DROP_W)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .sec_go   (sec_go),
    .sec_stop (sec_stop),
    .clr_req  (clr_req),
    .snap_req (snap_req),
    .launch   (launch),
    .req_kind (req_kind),
    .req_sec  (req_sec),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  assign launch = (state_q == ST_IDLE) && (req_kind != REQ_NONE);
  assign busy   = (state_q != ST_IDLE) || pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_kind == REQ_SNAP)      state_d = ST_RD_ADDR;
        else if (req_kind != REQ_NONE) state_d = ST_WR;
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP:  state_d = ST_PUSH;
      ST_PUSH: begin
        if (smp_ready) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_RD_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; address/data hold between transfers.
  always_comb begin
    address_d   = pcu_address;
    writedata_d = pcu_writedata;
    write_d     = 1'b0;
    bt_d        = 1'b0;
    idx_d       = idx_q;
    smp_valid_d = (state_d == ST_PUSH);
    smp_data_d  = smp_data;
    smp_addr_d  = smp_addr;
    smp_last_d  = smp_last;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          bt_d = 1'b1;
          if (req_kind == REQ_SNAP) begin
            idx_d     = 4'd0;
            address_d = snap_addr(4'd0);
          end else begin
            write_d     = 1'b1;
            address_d   = wr_addr(req_kind, req_sec);
            writedata_d = (req_kind == REQ_CLR) ? CLR_DATA : 32'd0;
          end
        end
      end
      ST_RD_CAP: begin
        smp_data_d = pcu_readdata;
        smp_addr_d = snap_addr(idx_q);
        smp_last_d = (idx_q == LAST_IDX);
      end
      ST_PUSH: begin
        if (smp_ready && idx_q != LAST_IDX) begin
          idx_d     = idx_q + 4'd1;
          address_d = snap_addr(idx_q + 4'd1);
          bt_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcu_address       <= 4'd0;
      pcu_write         <= 1'b0;
      pcu_begintransfer <= 1'b0;
      pcu_writedata     <= 32'd0;
      smp_valid         <= 1'b0;
      smp_data          <= 32'd0;
      smp_addr          <= 4'd0;
      smp_last          <= 1'b0;
      idx_q             <= 4'd0;
    end else begin
      pcu_address       <= address_d;
      pcu_write         <= write_d;
      pcu_begintransfer <= bt_d;
      pcu_writedata     <= writedata_d;
      smp_valid         <= smp_valid_d;
      smp_data          <= smp_data_d;
      smp_addr          <= smp_addr_d;
      smp_last          <= smp_last_d;
      idx_q             <= idx_d;
    end
  end

endmodule
